// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch/hazard controller: FSM states and next-PC selects.
package fetch_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSHED = 2'd2,
    WAIT    = 2'd3
  } state_t;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

endpackage

// File: rtl/fetch_ctrl_lu_detect.sv
// Load-use hazard compare between the load in EX and the source registers of ID.
module lu_detect
  import fetch_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt && (ex_rt == id_rt);
  assign lu     = ex_memread && (ex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/hazard controller: PC advance, branch/jump redirect, load-use bubble, memory freeze.
// Optional statistics counters (stall_cnt, flush_cnt) are built when FETCH_STATS_EN is defined.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic [1:0]       state,
  output logic             mem_timeout
`ifdef FETCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state_reg;
  state_t            state_next;
  state_t            ret_state_reg;
  state_t            eff_state;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              mem_timeout_reg;
  logic              lu;

  lu_detect u_lu_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu         (lu)
  );

  // While frozen, hazard gating must reflect where the pipe was before the freeze
  assign eff_state = (state_reg == WAIT) ? ret_state_reg : state_reg;

  always_comb begin
    pc_write   = 1'b1;
    pc_sel     = PCSEL_SEQ;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_write = 1'b1;
    idex_flush = 1'b0;
    exmem_hold = 1'b0;
    state_next = RUN;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      exmem_hold = 1'b1;
      state_next = WAIT;
    end else if (ex_branch_taken) begin
      pc_sel     = PCSEL_BR;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_next = FLUSHED;
    end else if (lu && (eff_state == RUN || eff_state == WAIT)) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_next = STALL;
    end else if (id_jump && eff_state != FLUSHED) begin
      pc_sel     = PCSEL_JMP;
      ifid_flush = 1'b1;
      state_next = FLUSHED;
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (mem_busy) begin
      wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      ret_state_reg   <= RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      // Capture the pre-freeze state only on entry; back-to-back busy cycles keep it
      if (mem_busy && state_reg != WAIT) begin
        ret_state_reg <= state_reg;
      end
      if (wait_cnt_next == WAIT_MAX) begin
        mem_timeout_reg <= 1'b1;
      end
    end
  end

  assign state       = state_reg;
  assign mem_timeout = mem_timeout_reg;

`ifdef FETCH_STATS_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             flush_evt;

  // Redirect and jump are exactly the non-freeze cycles that select a non-sequential PC
  assign flush_evt = !mem_busy && (pc_sel != PCSEL_SEQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_write && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (flush_evt && flush_cnt_reg != '1) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven checks of fetch_ctrl plus hand sequences for freeze timeout and reset.
module tb_fetch_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, ex_branch_taken, id_jump, mem_busy;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_hold;
  logic [1:0] pc_sel;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef FETCH_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .id_jump         (id_jump),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .pc_sel          (pc_sel),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_flush      (idex_flush),
    .exmem_hold      (exmem_hold),
    .state           (state),
    .mem_timeout     (mem_timeout)
`ifdef FETCH_STATS_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_flush, exmem_hold}
  localparam logic [7:0] O_DEF = 8'b1_00_1_0_1_0_0;
  localparam logic [7:0] O_LU  = 8'b0_00_0_0_1_1_0;
  localparam logic [7:0] O_BR  = 8'b1_01_1_1_1_1_0;
  localparam logic [7:0] O_JMP = 8'b1_10_1_1_1_0_0;
  localparam logic [7:0] O_FRZ = 8'b0_00_0_0_0_0_1;
  localparam logic [7:0] O_RST = 8'b0_00_0_1_0_1_0;

  localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_FL = 2'd2, S_WAIT = 2'd3;

  typedef struct {
    logic       busy, br, jmp, mr;
    logic [4:0] ex_rt, rs, rt;
    logic       urt;
    logic [7:0] exp_ctrl;
    logic [1:0] exp_state;
  } vec_t;

  logic [7:0] ctrl;
  assign ctrl = {pc_write, pc_sel, ifid_write, ifid_flush, idex_write, idex_flush, exmem_hold};

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic busy, logic br, logic jmp, logic mr, logic [4:0] xr,
                              logic [4:0] rs, logic [4:0] rt, logic urt,
                              logic [7:0] ec, logic [1:0] es);
    vec_t v;
    v.busy = busy; v.br = br; v.jmp = jmp; v.mr = mr;
    v.ex_rt = xr; v.rs = rs; v.rt = rt; v.urt = urt;
    v.exp_ctrl = ec; v.exp_state = es;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    mem_busy = v.busy; ex_branch_taken = v.br; id_jump = v.jmp; ex_memread = v.mr;
    ex_rt = v.ex_rt; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt;
  endtask

  task automatic step(vec_t v, string name);
    @(negedge clk);
    apply(v);
    #1 chk({name, "_ctrl"}, {24'd0, ctrl}, {24'd0, v.exp_ctrl});
    @(posedge clk);
    #1 chk({name, "_state"}, {30'd0, state}, {30'd0, v.exp_state});
    $display("txn %s ctrl=%b state=%0d timeout=%0b", name, ctrl, state, mem_timeout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, O_RST, S_RUN));
    #1 chk("rst_ctrl", {24'd0, ctrl}, {24'd0, O_RST});
    @(posedge clk);
    #1 chk("rst_state", {30'd0, state}, {30'd0, S_RUN});
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, O_RST, S_RUN));
    do_reset();

    //          busy br jmp mr xrt rs rt urt  ctrl   next
    vecs.push_back(mk(0, 0, 0, 1, 5, 5, 0, 0, O_LU,  S_STALL)); // load-use on rs
    vecs.push_back(mk(0, 0, 0, 1, 5, 5, 0, 0, O_DEF, S_RUN));   // no second bubble
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, O_DEF, S_RUN));   // r0 never hazards
    vecs.push_back(mk(0, 0, 0, 1, 7, 3, 7, 1, O_LU,  S_STALL)); // load-use on rt
    vecs.push_back(mk(0, 0, 0, 0, 7, 3, 7, 1, O_DEF, S_RUN));
    vecs.push_back(mk(0, 0, 0, 1, 7, 3, 7, 0, O_DEF, S_RUN));   // rt not read
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, O_BR,  S_FL));    // branch beats jump
    vecs.push_back(mk(0, 0, 1, 1, 4, 4, 0, 0, O_DEF, S_RUN));   // jump+lu ignored after flush
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, O_JMP, S_FL));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, O_DEF, S_RUN));   // jump ignored in FLUSHED
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, O_JMP, S_FL));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_FRZ, S_WAIT));  // freeze from FLUSHED
    vecs.push_back(mk(0, 0, 0, 1, 6, 6, 0, 0, O_DEF, S_RUN));   // release with lu: no bubble
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, O_FRZ, S_WAIT));  // freeze from RUN
    vecs.push_back(mk(1, 0, 0, 1, 6, 6, 0, 0, O_FRZ, S_WAIT));
    vecs.push_back(mk(0, 0, 0, 1, 6, 6, 0, 0, O_LU,  S_STALL)); // release with lu: bubble
    vecs.push_back(mk(1, 0, 0, 1, 6, 6, 0, 0, O_FRZ, S_WAIT));  // freeze from STALL
    vecs.push_back(mk(0, 0, 0, 1, 6, 6, 0, 0, O_DEF, S_RUN));   // lu gated by saved STALL
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, O_FRZ, S_WAIT));  // freeze beats branch
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, O_BR,  S_FL));    // branch retaken
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, O_BR,  S_FL));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, S_RUN));

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));
    chk("table_timeout", {31'd0, mem_timeout}, 32'd0);

    // 16 busy cycles with a taken branch pending: timeout visible from cycle 15
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, O_FRZ, S_WAIT));
      #1 chk($sformatf("frz%0d_ctrl", k), {24'd0, ctrl}, {24'd0, O_FRZ});
      chk($sformatf("frz%0d_timeout", k), {31'd0, mem_timeout}, {31'd0, (k >= 15)});
      $display("txn frz%0d ctrl=%b timeout=%0b", k, ctrl, mem_timeout);
    end
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, O_BR, S_FL), "release_br");
    chk("release_timeout", {31'd0, mem_timeout}, 32'd1);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, S_RUN), "post_release");
    chk("sticky_timeout", {31'd0, mem_timeout}, 32'd1);

    // Reset mid-stall abandons the bubble sequence
    step(mk(0, 0, 0, 1, 9, 9, 0, 0, O_LU, S_STALL), "pre_rst_lu");
    do_reset();
    step(mk(0, 0, 0, 1, 9, 9, 0, 0, O_LU, S_STALL), "post_rst_lu");

    // Reset mid-freeze clears the saved return state
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, O_FRZ, S_WAIT), "pre_rst_frz");
    do_reset();
    step(mk(0, 0, 0, 1, 9, 9, 0, 0, O_LU, S_STALL), "post_rst_frz_lu");

`ifdef FETCH_STATS_EN
    do_reset();
    chk("stall_cnt_rst", {16'd0, stall_cnt}, 32'd0);
    chk("flush_cnt_rst", {16'd0, flush_cnt}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      step(mk(0, 0, 0, 1, 5, 5, 0, 0, O_LU, S_STALL), $sformatf("st_lu%0d", n));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, S_RUN), $sformatf("st_run%0d", n));
    end
    for (int n = 0; n < 2; n++) begin
      step(mk(0, 0, 1, 0, 0, 0, 0, 0, O_JMP, S_FL), $sformatf("st_jmp%0d", n));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, O_DEF, S_RUN), $sformatf("st_def%0d", n));
    end
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd3);
    chk("flush_cnt", {16'd0, flush_cnt}, 32'd2);
    do_reset();
    chk("stall_cnt_clr", {16'd0, stall_cnt}, 32'd0);
    chk("flush_cnt_clr", {16'd0, flush_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
